// File: rtl/spi_resp_pkg.sv
// Shared types and defaults for the SPI word responder.
package spi_resp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_resp_state_e;

  localparam int          SPI_RESP_WORD_W = 32;
  localparam logic [31:0] SPI_RESP_FILL   = 32'hFFFF_FFFF;
  localparam int          SPI_RESP_BITS_W = 6;

endpackage

// File: rtl/spi_resp_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with level and
// single-cycle rise/fall events derived from an edge register.
module spi_resp_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      edge_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~edge_q;
  assign fall_o  = ~sync_q[STAGES-1] & edge_q;

endmodule

// File: rtl/spi_word_responder.sv
// SPI mode-0 responder with a one-deep transmit holding register and word-wise receive.
// Optional SPI_RESP_LSB_FIRST_EN switches both shift registers to LSB-first.
module spi_word_responder
  import spi_resp_pkg::*;
#(
  parameter int          WORD_W      = SPI_RESP_WORD_W,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] FILL_WORD   = SPI_RESP_FILL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       spi_sck,
  input  logic                       spi_cs_n,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic                       spi_miso_oe,
  input  logic [WORD_W-1:0]          tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [WORD_W-1:0]          rx_data,
  output logic [SPI_RESP_BITS_W-1:0] rx_bits,
  output logic                       rx_valid,
  output logic                       tx_underrun,
  output logic                       busy
);

  localparam logic [SPI_RESP_BITS_W-1:0] WORD_BITS  = SPI_RESP_BITS_W'(WORD_W);
  localparam logic [7:0]                 SETTLE_CNT = 8'(SYNC_STAGES + 1);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .async_i(spi_sck),
    .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .async_i(spi_cs_n),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(spi_mosi),
    .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

  spi_resp_state_e             state_q;
  logic                        armed_q;
  logic [7:0]                  settle_q;
  logic [WORD_W-1:0]           hold_q;
  logic                        hold_full_q;
  logic [WORD_W-1:0]           tx_shift_q;
  logic [WORD_W-1:0]           rx_shift_q;
  logic [SPI_RESP_BITS_W-1:0]  count_q;
  logic                        reload_pending_q;
  logic                        miso_q;
  logic                        miso_oe_q;
  logic [WORD_W-1:0]           rx_data_q;
  logic [SPI_RESP_BITS_W-1:0]  rx_bits_q;
  logic                        rx_valid_q;
  logic                        tx_underrun_q;
  logic                        busy_q;

  logic [WORD_W-1:0]           load_word;
  logic                        load_from_hold;
  logic                        load_bypass;
  logic                        load_fill;
  logic                        load_bit;
  logic [WORD_W-1:0]           tx_shift_d;
  logic                        shift_bit;
  logic [WORD_W-1:0]           rx_shift_d;
  logic [SPI_RESP_BITS_W-1:0]  count_d;
  logic                        word_done;
  logic                        frame_start;
  logic                        reload_now;
  logic                        tx_load;
  logic                        hold_accept;

`ifdef SPI_RESP_LSB_FIRST_EN
  assign load_bit   = load_word[0];
  assign tx_shift_d = tx_shift_q >> 1;
  assign shift_bit  = tx_shift_d[0];
  assign rx_shift_d = rx_shift_q | ({{(WORD_W-1){1'b0}}, mosi_level} << count_q);
`else
  assign load_bit   = load_word[WORD_W-1];
  assign tx_shift_d = tx_shift_q << 1;
  assign shift_bit  = tx_shift_d[WORD_W-1];
  assign rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_level};
`endif

  // Source for a tx shift load: holding register, same-cycle bypass, or fill word.
  always_comb begin
    load_word      = FILL_WORD[WORD_W-1:0];
    load_from_hold = 1'b0;
    load_bypass    = 1'b0;
    load_fill      = 1'b0;
    if (hold_full_q) begin
      load_word      = hold_q;
      load_from_hold = 1'b1;
    end else if (tx_valid) begin
      load_word   = tx_data;
      load_bypass = 1'b1;
    end else begin
      load_fill = 1'b1;
    end
  end

  assign count_d     = count_q + 6'd1;
  assign word_done   = sck_rise & (count_d == WORD_BITS);
  assign frame_start = (state_q == ST_IDLE) & cs_fall & armed_q;
  assign reload_now  = (state_q == ST_SHIFT) & sck_fall & ~cs_rise & reload_pending_q;
  assign tx_load     = frame_start | reload_now;
  // A bypass load consumes tx_valid directly, so the holding register must not take it too.
  assign hold_accept = tx_valid & ~hold_full_q & ~(tx_load & load_bypass);

  // Frame FSM, holding register, shift registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      armed_q          <= 1'b0;
      settle_q         <= 8'd0;
      hold_q           <= '0;
      hold_full_q      <= 1'b0;
      tx_shift_q       <= '0;
      rx_shift_q       <= '0;
      count_q          <= '0;
      reload_pending_q <= 1'b0;
      miso_q           <= 1'b1;
      miso_oe_q        <= 1'b0;
      rx_data_q        <= '0;
      rx_bits_q        <= '0;
      rx_valid_q       <= 1'b0;
      tx_underrun_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;

      // The cs_n synchronizer holds its reset value until real pin samples reach the end.
      if (settle_q != SETTLE_CNT) begin
        settle_q <= settle_q + 8'd1;
      end

      if (hold_accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (tx_load && load_from_hold) begin
        hold_full_q <= 1'b0;
      end

      if (tx_load) begin
        tx_shift_q       <= load_word;
        miso_q           <= load_bit;
        tx_underrun_q    <= load_fill;
        reload_pending_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          if ((settle_q == SETTLE_CNT) && cs_level) begin
            armed_q <= 1'b1;
          end
          if (frame_start) begin
            state_q    <= ST_SHIFT;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
            count_q    <= '0;
            rx_shift_q <= '0;
          end
        end

        ST_SHIFT: begin
          if (sck_rise) begin
            if (word_done) begin
              rx_data_q        <= rx_shift_d;
              rx_bits_q        <= WORD_BITS;
              rx_valid_q       <= 1'b1;
              count_q          <= '0;
              rx_shift_q       <= '0;
              reload_pending_q <= 1'b1;
            end else begin
              rx_shift_q <= rx_shift_d;
              count_q    <= count_d;
            end
          end

          // A sample landing with the cs_n rise is folded into the closing partial word.
          if (cs_rise) begin
            if (sck_rise && !word_done) begin
              rx_data_q  <= rx_shift_d;
              rx_bits_q  <= count_d;
              rx_valid_q <= 1'b1;
            end else if (!sck_rise && (count_q != '0)) begin
              rx_data_q  <= rx_shift_q;
              rx_bits_q  <= count_q;
              rx_valid_q <= 1'b1;
            end
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b1;
          end else if (sck_fall && !reload_pending_q) begin
            tx_shift_q <= tx_shift_d;
            miso_q     <= shift_bit;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          miso_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_bits     = rx_bits_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_word_responder.sv
// Directed bench for spi_word_responder: an SPI mode-0 master model driving frames.
`timescale 1ns/1ps
module tb_spi_word_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [31:0] tx_data = 32'h0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic [5:0]  rx_bits;
  logic        rx_valid;
  logic        tx_underrun;
  logic        busy;

  spi_word_responder dut (
    .clk(clk), .reset(reset),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_bits(rx_bits), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad = 0;
  int          rx_cnt = 0;
  int          und_cnt = 0;
  logic [31:0] last_data = 32'h0;
  logic [5:0]  last_bits = 6'd0;
  logic [31:0] rx_log[$];
  logic        first_ready, first_busy, first_oe;
  logic [63:0] cap;
  int          rx0, und0;
  logic        m;

  // Event monitor: tallies rx_valid / tx_underrun pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt    <= rx_cnt + 1;
      last_data <= rx_data;
      last_bits <= rx_bits;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun) und_cnt <= und_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [31:0] w);
    int n = 0;
    while (!tx_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_ready_wait", 64'(tx_ready), 64'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic do_bit(input logic b, input logic raise_cs, input logic drop, output logic mo);
    spi_mosi = b;
    wait_neg(HALF);
    mo = spi_miso;
    spi_sck = 1'b1;
    if (raise_cs) spi_cs_n = 1'b1;
    wait_neg(HALF);
    if (drop) spi_sck = 1'b0;
  endtask

  task automatic run_frame(input logic [63:0] w, input int nbits, input logic sim_end,
                           output logic [63:0] c);
    logic mo;
    c = 64'h0;
    spi_mosi = w[nbits-1];
    spi_cs_n = 1'b0;
    wait_neg(HALF);
    first_ready = tx_ready;
    first_busy  = busy;
    first_oe    = spi_miso_oe;
    for (int i = nbits - 1; i >= 0; i--) begin
      do_bit(w[i], sim_end && (i == 0), i != 0, mo);
      c = {c[62:0], mo};
    end
    if (!sim_end) begin
      spi_cs_n = 1'b1;
      wait_neg(HALF);
    end
    spi_sck = 1'b0;
    wait_neg(2 * HALF);
  endtask

  initial begin
    wait_neg(5);
    reset = 1'b0;
    wait_neg(5);
    check_eq("rst_miso", 64'(spi_miso), 64'd1);
    check_eq("rst_oe", 64'(spi_miso_oe), 64'd0);
    check_eq("rst_tx_ready", 64'(tx_ready), 64'd1);
    check_eq("rst_rx_data", 64'(rx_data), 64'd0);
    check_eq("rst_rx_bits", 64'(rx_bits), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_pulses", 64'(rx_cnt + und_cnt), 64'd0);

    // 32-bit frame with a preloaded word
    push_tx(32'hA5C3_0F01);
    rx0 = rx_cnt; und0 = und_cnt;
    run_frame(64'h1234_5678, 32, 1'b0, cap);
    check_eq("t1_miso", cap, 64'hA5C3_0F01);
    check_eq("t1_rx_cnt", 64'(rx_cnt - rx0), 64'd1);
    check_eq("t1_rx_data", 64'(last_data), 64'h1234_5678);
    check_eq("t1_rx_bits", 64'(last_bits), 64'd32);
    check_eq("t1_ready_in_frame", 64'(first_ready), 64'd1);
    check_eq("t1_busy_in_frame", 64'(first_busy), 64'd1);
    check_eq("t1_oe_in_frame", 64'(first_oe), 64'd1);
    check_eq("t1_underruns", 64'(und_cnt - und0), 64'd0);
    check_eq("t1_oe_after", 64'(spi_miso_oe), 64'd0);
    check_eq("t1_busy_after", 64'(busy), 64'd0);

    // 8-bit partial word closed by CS rise
    rx0 = rx_cnt; und0 = und_cnt;
    run_frame(64'hB7, 8, 1'b0, cap);
    check_eq("t2_miso", cap, 64'hFF);
    check_eq("t2_rx_cnt", 64'(rx_cnt - rx0), 64'd1);
    check_eq("t2_rx_data", 64'(last_data), 64'h0000_00B7);
    check_eq("t2_rx_bits", 64'(last_bits), 64'd8);
    check_eq("t2_underruns", 64'(und_cnt - und0), 64'd1);

    // underrun: nothing loaded
    rx0 = rx_cnt; und0 = und_cnt;
    run_frame(64'h0F1E_2D3C, 32, 1'b0, cap);
    check_eq("t3_miso", cap, 64'hFFFF_FFFF);
    check_eq("t3_underruns", 64'(und_cnt - und0), 64'd1);
    check_eq("t3_rx_cnt", 64'(rx_cnt - rx0), 64'd1);
    check_eq("t3_rx_data", 64'(last_data), 64'h0F1E_2D3C);
    check_eq("t3_rx_bits", 64'(last_bits), 64'd32);

    // 64-bit frame, second word loaded while the first shifts
    push_tx(32'h1111_1111);
    rx0 = rx_cnt; und0 = und_cnt;
    fork
      run_frame(64'hDEAD_BEEF_CAFE_F00D, 64, 1'b0, cap);
      push_tx(32'h2222_2222);
    join
    check_eq("t4_miso", cap, 64'h1111_1111_2222_2222);
    check_eq("t4_rx_cnt", 64'(rx_cnt - rx0), 64'd2);
    check_eq("t4_rx_word0", 64'(rx_log[rx_log.size() - 2]), 64'hDEAD_BEEF);
    check_eq("t4_rx_word1", 64'(rx_log[rx_log.size() - 1]), 64'hCAFE_F00D);
    check_eq("t4_underruns", 64'(und_cnt - und0), 64'd0);
    check_eq("t4_tx_ready", 64'(tx_ready), 64'd1);

    // reset at bit 10 with CS held low
    rx0 = rx_cnt;
    spi_mosi = 1'b1;
    spi_cs_n = 1'b0;
    wait_neg(HALF);
    for (int i = 0; i < 10; i++) do_bit(1'b1, 1'b0, 1'b1, m);
    reset = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(1);
    check_eq("t5_oe_rst", 64'(spi_miso_oe), 64'd0);
    check_eq("t5_miso_rst", 64'(spi_miso), 64'd1);
    check_eq("t5_busy_rst", 64'(busy), 64'd0);
    check_eq("t5_rx_data_rst", 64'(rx_data), 64'd0);
    for (int i = 0; i < 22; i++) do_bit(1'b1, 1'b0, 1'b1, m);
    check_eq("t5_oe_ignored", 64'(spi_miso_oe), 64'd0);
    check_eq("t5_busy_ignored", 64'(busy), 64'd0);
    check_eq("t5_rx_none", 64'(rx_cnt - rx0), 64'd0);
    spi_cs_n = 1'b1;
    wait_neg(2 * HALF);
    push_tx(32'h0F0F_3C3C);
    rx0 = rx_cnt;
    run_frame(64'h89AB_CDEF, 32, 1'b0, cap);
    check_eq("t5_miso", cap, 64'h0F0F_3C3C);
    check_eq("t5_rx_cnt", 64'(rx_cnt - rx0), 64'd1);
    check_eq("t5_rx_data", 64'(last_data), 64'h89AB_CDEF);
    check_eq("t5_rx_bits", 64'(last_bits), 64'd32);

    // CS rise together with the 32nd SCK rise
    push_tx(32'h5A5A_5A5A);
    rx0 = rx_cnt;
    run_frame(64'hC001_D00D, 32, 1'b1, cap);
    check_eq("t6_miso", cap, 64'h5A5A_5A5A);
    check_eq("t6_rx_cnt", 64'(rx_cnt - rx0), 64'd1);
    check_eq("t6_rx_data", 64'(last_data), 64'hC001_D00D);
    check_eq("t6_rx_bits", 64'(last_bits), 64'd32);
    check_eq("t6_oe", 64'(spi_miso_oe), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
